ddr2_sys_master_0_st_channel_arbiter: RTL and testbench
=======================================================

Name: ddr2_sys_master_0_st_channel_arbiter

Overview:
Packet-level round-robin arbiter that shares the master's single Avalon-ST byte path between NUM_IN packet sources. It grants one input at a time and holds the grant for the whole packet, from the startofpacket beat to the endofpacket beat. It forwards beats through one registered output stage and tags each beat with out_channel set to the granted input index. Its output feeds the packets-to-bytes channel adapter stage of the master.

Parameters:
NUM_IN, 4, number of requesting input streams (2..8)
DATA_W, 8, data width per beat
CH_W, 8, out_channel width (must be >= clog2(NUM_IN))

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  NUM_IN  per-input beat valid
in_data  input  NUM_IN*DATA_W  per-input data; input i occupies [i*DATA_W +: DATA_W]
in_startofpacket  input  NUM_IN  per-input SOP
in_endofpacket  input  NUM_IN  per-input EOP
in_ready  output  NUM_IN  per-input ready; only the granted bit can be 1
out_ready  input  1  downstream ready
out_valid  output  1  registered beat valid
out_data  output  DATA_W  registered data
out_startofpacket  output  1  registered SOP
out_endofpacket  output  1  registered EOP
out_channel  output  CH_W  registered channel; zero-extended index of the granted input
busy  output  1  1 while in the LOCKED state
grant_id  output  clog2(NUM_IN)  current or last granted index

Behaviour:
- Reset (synchronous, reset=1 sampled at the clk edge):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, busy=0.
  - in_ready is all 0 in the following cycle.
  - A reset mid-packet abandons the packet. No EOP is synthesised; the downstream consumer must resync on SOP.
- Output stage:
  - load = !out_valid || out_ready.
  - in_ready[g] = (state==LOCKED) && load, where g is the granted input. All other in_ready bits are 0.
  - On in_valid[g] && in_ready[g]: the output registers capture data, SOP, EOP and channel=g, and out_valid is set to 1.
  - On out_ready with no new beat captured: out_valid is cleared to 0.
  - Throughput is one beat per cycle while LOCKED and the downstream is ready.
- State IDLE:
  - If any in_valid bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_IN.
  - Register that index into grant_id and go to LOCKED.
  - Arbitration looks only at in_valid, not at SOP. Beats are forwarded with their flags unchanged.
  - No beat is accepted in IDLE.
- State LOCKED:
  - Forward beats from input g.
  - When a beat with in_endofpacket[g]=1 is accepted: go to IDLE and set rr_ptr=(g+1) mod NUM_IN.
  - A single-beat packet (SOP=EOP=1) locks for exactly one accepted beat.
  - in_valid[g] dropping mid-packet holds the grant indefinitely; there is no timeout.
- Latency:
  - Request visible in IDLE at cycle t -> grant_id/LOCKED at t+1.
  - First beat accepted at t+1 -> out_valid=1 at t+2.
  - EOP accepted at cycle u -> IDLE at u+1 -> next grant at u+2. This gives a minimum 2-cycle gap between packets on the input side.
- Boundary conditions:
  - Simultaneous requests resolve purely by rotating priority; there is no fixed priority.
  - rr_ptr wraps from NUM_IN-1 to 0.
  - Backpressure (out_ready=0 with out_valid=1) holds all output registers stable and drives in_ready low.
  - EOP acceptance and out_ready in the same cycle are handled independently by the rules above.

Optional Feature:
ST_ARB_CHANNEL_MASK_EN:
- Defined:
  - Adds input port chan_mask [NUM_IN].
  - IDLE arbitration considers in_valid & ~chan_mask.
  - A masked input is never granted and its in_ready stays 0.
  - The mask is sampled only in IDLE; setting a mask bit for the granted input while LOCKED does not break the packet.
  - All inputs masked -> the block stays in IDLE.
- Not defined: no port; all inputs are eligible.

Test Plan:
- Reset, then in_valid[2]=1 with a 3-beat packet 0xA1,0xA2,0xA3 (SOP on the first, EOP on the last) -> grant_id=2 one cycle later; out beats A1/A2/A3 with out_channel=2, SOP/EOP on the first/last; then rr_ptr=3.
- All 4 inputs continuously requesting 1-beat packets -> grant order 0,1,2,3,0 with out_channel following that order; consecutive grants separated by 2 cycles.
- During input 1's 4-beat packet, hold out_ready=0 for 5 cycles on beat 2 -> out_data stable, in_ready[1]=0, no beat lost or duplicated, and no switch to another input despite in_valid[0]=1.
- Input 3 drops in_valid for 10 cycles mid-packet while input 0 requests -> grant held on 3, busy=1, input 0 served only after input 3's EOP.
- Assert reset in the middle of input 0's packet -> next cycle out_valid=0, in_ready=0, busy=0, grant_id=0; a subsequent request on input 1 is granted normally.
- With ST_ARB_CHANNEL_MASK_EN: chan_mask=4'b0101 and all inputs requesting -> only inputs 1 and 3 are granted, alternating.

Source files
------------

// File: rtl/ddr2_sys_master_0_st_channel_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_sys_master_0_st_channel_arbiter
//
// Packet-level round-robin arbiter. It shares one Avalon-ST byte path between
// NUM_IN packet sources. One input is granted at a time, and the grant is held
// from the first accepted beat until the accepted EOP beat. Beats pass through
// a single registered output stage. Each beat is tagged with the granted index
// on out_channel.
//
// Handshake (applies to every valid/ready pair in this block):
//   A beat transfers on a rising clk edge where valid && ready are both 1.
//   Valid does not depend on ready. Ready may depend on valid, but here it
//   depends only on arbiter state and on the output stage.
//
// Optional build macro:
//   ST_ARB_CHANNEL_MASK_EN - adds input chan_mask[NUM_IN]. A masked input is
//                            excluded from arbitration. The mask is sampled
//                            only while IDLE.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_data/in_startofpacket/in_endofpacket/in_ready
//                     per-input sink side; input i data at [i*DATA_W +: DATA_W]
//   out_valid/out_data/out_startofpacket/out_endofpacket/out_channel/out_ready
//                     registered source side
//   busy              1 while LOCKED (doubles as the FSM state debug view)
//   grant_id          current or last granted input index
// ---------------------------------------------------------------------------
module ddr2_sys_master_0_st_channel_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 8,
  localparam int GW    = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic [NUM_IN-1:0]        in_ready,
`ifdef ST_ARB_CHANNEL_MASK_EN
  input  logic [NUM_IN-1:0]        chan_mask,
`endif
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CH_W-1:0]          out_channel,
  output logic                     busy,
  output logic [GW-1:0]            grant_id
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [NUM_IN-1:0]   eligible;
  logic                pick_found;
  logic [GW-1:0]       pick_idx;
  logic                sel_valid, sel_sop, sel_eop;
  logic [DATA_W-1:0]   sel_data;
  logic                load, accept, eop_accept;

  // (base + off) mod NUM_IN. off never exceeds NUM_IN, so a single
  // subtraction is enough to wrap.
  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return s[GW-1:0];
  endfunction

`ifdef ST_ARB_CHANNEL_MASK_EN
  assign eligible = in_valid & ~chan_mask;
`else
  assign eligible = in_valid;
`endif

  // Rotating priority search. The loop walks from the farthest offset down to
  // offset 0, so the last hit is the first set bit at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (eligible[wrap_inc(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_inc(rr_ptr, k);
      end
    end
  end

  // Mux for the granted input's sideband and data.
  always_comb begin
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (GW'(i) == grant_id) begin
        sel_valid = in_valid[i];
        sel_sop   = in_startofpacket[i];
        sel_eop   = in_endofpacket[i];
        sel_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign load       = !out_valid || out_ready;
  assign accept     = (state == ST_LOCKED) && load && sel_valid;
  assign eop_accept = accept && sel_eop;

  // FSM: state register (also holds the round-robin pointer and the grant).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // A dropped in_valid mid-packet keeps the lock indefinitely.
        if (eop_accept) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = wrap_inc(grant_id, 1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs decoded from the state.
  always_comb begin
    busy     = (state == ST_LOCKED);
    in_ready = '0;
    if ((state == ST_LOCKED) && load) in_ready[grant_id] = 1'b1;
  end

  // Registered output stage. Data and flags keep their last value when
  // out_valid drops. Only out_valid is qualified by out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_data          <= sel_data;
      out_startofpacket <= sel_sop;
      out_endofpacket   <= sel_eop;
      out_channel       <= CH_W'(grant_id);
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr2_sys_master_0_st_channel_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for ddr2_sys_master_0_st_channel_arbiter (NUM_IN=4, DATA_W=8, CH_W=8).
// Per-input packet queues model the sources. Every accepted input beat pushes
// {channel, eop, sop, data} into exp_q. Every output transfer pops exp_q and
// compares. The grant order is logged from accepted SOP beats.
// ---------------------------------------------------------------------------
module tb_ddr2_sys_master_0_st_channel_arbiter;
  localparam int NUM_IN = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 8;
  localparam int GW     = 2;
  localparam int EW     = CH_W + 2 + DATA_W;

  logic                     clk;
  logic                     reset;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN-1:0]        chan_mask;
  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CH_W-1:0]          out_channel;
  logic                     busy;
  logic [GW-1:0]            grant_id;

  ddr2_sys_master_0_st_channel_arbiter #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .CH_W(CH_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_ready          (in_ready),
`ifdef ST_ARB_CHANNEL_MASK_EN
    .chan_mask         (chan_mask),
`endif
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  // ---------------- clock / reset control ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [9:0]        src_q [NUM_IN][$];  // {eop, sop, data}
  logic [EW-1:0]     exp_q[$];           // {channel, eop, sop, data}
  int                grant_ch[$];
  int                grant_cyc[$];
  int                exp_g[$];
  int                acc_cnt [NUM_IN];
  logic [NUM_IN-1:0] hold;
  logic [NUM_IN-1:0] hs_prev;
  logic              rst_next;
  logic              or_next;
  int                cyc;
  int                n_checks;
  int                n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_pkt(input int ch, input int len, input logic [7:0] base);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = base + 8'(b);
      src_q[ch].push_back({(b == len - 1), (b == 0), d});
    end
  endtask

  // One clock cycle. Inputs are driven at the falling edge, and the monitor
  // samples 1 ns later. Both hold steady through the next rising edge.
  task automatic step();
    logic [9:0]     bt;
    logic [EW-1:0]  e;
    logic [NUM_IN-1:0] hs;
    @(negedge clk);
    reset     = rst_next;
    out_ready = or_next;
    for (int i = 0; i < NUM_IN; i++)
      if (hs_prev[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        bt = src_q[i][0];
        in_valid[i]                  = 1'b1;
        in_data[i*DATA_W +: DATA_W]  = bt[7:0];
        in_startofpacket[i]          = bt[8];
        in_endofpacket[i]            = bt[9];
      end else begin
        in_valid[i]         = 1'b0;
        in_startofpacket[i] = 1'b0;
        in_endofpacket[i]   = 1'b0;
      end
    end
    #1;
    cyc++;
    if (reset) begin
      exp_q.delete();
      hs_prev = '0;
      return;
    end
    // Scoreboard: an output transfer happens at the coming edge.
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_beat", {out_channel, out_endofpacket, out_startofpacket, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", {out_channel, out_endofpacket, out_startofpacket, out_data}, e);
      end
    end
    check("in_ready_onehot", ($countones(in_ready) <= 1), 1);
    hs = in_valid & in_ready;
    for (int i = 0; i < NUM_IN; i++) begin
      if (hs[i]) begin
        exp_q.push_back({CH_W'(i), in_endofpacket[i], in_startofpacket[i], in_data[i*DATA_W +: DATA_W]});
        acc_cnt[i]++;
        if (in_startofpacket[i]) begin
          grant_ch.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
    end
    hs_prev = hs;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() > 0 && !hold[i]) p = 1'b1;
    return p || (exp_q.size() > 0) || out_valid || busy;
  endfunction

  task automatic drain(input string tag);
    int budget = 3000;
    while (pending() && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_drain_timeout"}, (budget == 0), 0);
  endtask

  task automatic wait_acc(input int ch, input int n, input string tag);
    int budget = 200;
    while (acc_cnt[ch] < n && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_accept_timeout"}, (budget == 0), 0);
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_grant_count"}, grant_ch.size(), exp_g.size());
    for (int k = 0; k < exp_g.size() && k < grant_ch.size(); k++)
      check({tag, "_grant_order"}, grant_ch[k], exp_g[k]);
  endtask

  task automatic clear_logs();
    grant_ch.delete();
    grant_cyc.delete();
    exp_g.delete();
    for (int i = 0; i < NUM_IN; i++) acc_cnt[i] = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    hold     = '0;
    or_next  = 1'b1;
    rst_next = 1'b1;
    step();
    step();
    rst_next = 1'b0;
    clear_logs();
  endtask

  // ---------------- tests ----------------
  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; in_startofpacket = '0;
    in_endofpacket = '0; chan_mask = '0; out_ready = 1'b1;
    hold = '0; hs_prev = '0; rst_next = 1'b1; or_next = 1'b1;
    cyc = 0; n_checks = 0; n_errors = 0;

    // Reset state
    do_reset();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sop", out_startofpacket, 0);
    check("rst_out_eop", out_endofpacket, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_in_ready", in_ready, 0);

    // Test 1: 3-beat packet on input 2, grant latency, then rr_ptr = 3
    do_reset();
    add_pkt(2, 3, 8'hA1);
    step();
    check("t1_idle_no_accept", in_ready, 0);
    check("t1_idle_busy", busy, 0);
    step();
    check("t1_grant_id", grant_id, 2);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 4'b0100);
    step();
    check("t1_first_out_valid", out_valid, 1);
    check("t1_first_out_data", out_data, 8'hA1);
    drain("t1");
    exp_g.push_back(2);
    check_grants("t1");
    clear_logs();
    add_pkt(0, 1, 8'h50);
    add_pkt(3, 1, 8'h53);
    drain("t1_rr");
    exp_g.push_back(3); exp_g.push_back(0);
    check_grants("t1_rr");

    // Test 2: all inputs streaming 1-beat packets
    do_reset();
    for (int i = 0; i < NUM_IN; i++) begin
      add_pkt(i, 1, 8'h10 + 8'(i));
      add_pkt(i, 1, 8'h20 + 8'(i));
    end
    drain("t2");
    for (int r = 0; r < 2; r++) for (int i = 0; i < NUM_IN; i++) exp_g.push_back(i);
    check_grants("t2");
    for (int k = 0; k + 1 < grant_cyc.size(); k++)
      check("t2_grant_gap", grant_cyc[k+1] - grant_cyc[k], 2);

    // Test 3: backpressure on beat 2 of input 1 while input 0 requests
    do_reset();
    add_pkt(1, 4, 8'hB1);
    wait_acc(1, 1, "t3");
    add_pkt(0, 2, 8'hC1);
    wait_acc(1, 2, "t3");
    or_next = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_bp_out_valid", out_valid, 1);
      check("t3_bp_out_data", out_data, 8'hB2);
      check("t3_bp_in_ready", in_ready, 0);
      check("t3_bp_grant", grant_id, 1);
    end
    or_next = 1'b1;
    drain("t3");
    check("t3_acc1", acc_cnt[1], 4);
    check("t3_acc0", acc_cnt[0], 2);
    exp_g.push_back(1); exp_g.push_back(0);
    check_grants("t3");

    // Test 4: input 3 stalls mid-packet for 10 cycles; input 0 must wait
    do_reset();
    add_pkt(3, 3, 8'hD1);
    wait_acc(3, 1, "t4");
    add_pkt(0, 1, 8'hE1);
    hold[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4_busy", busy, 1);
      check("t4_grant", grant_id, 3);
      check("t4_in_ready0", in_ready[0], 0);
    end
    hold[3] = 1'b0;
    drain("t4");
    exp_g.push_back(3); exp_g.push_back(0);
    check_grants("t4");

    // Test 5: reset in the middle of input 0's packet
    do_reset();
    add_pkt(0, 5, 8'hF1);
    wait_acc(0, 2, "t5");
    src_q[0].delete();
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    clear_logs();
    step();
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_grant_id", grant_id, 0);
    add_pkt(1, 1, 8'h71);
    step();
    step();
    check("t5_regrant", grant_id, 1);
    drain("t5");
    exp_g.push_back(1);
    check_grants("t5");

`ifdef ST_ARB_CHANNEL_MASK_EN
    // Test 6: masked inputs 0 and 2 are never granted
    do_reset();
    chan_mask = 4'b0101;
    for (int i = 0; i < NUM_IN; i++) begin
      add_pkt(i, 1, 8'h30 + 8'(i));
      add_pkt(i, 1, 8'h40 + 8'(i));
    end
    for (int k = 0; k < 30; k++) step();
    exp_g.push_back(1); exp_g.push_back(3); exp_g.push_back(1); exp_g.push_back(3);
    check_grants("t6");
    check("t6_q0_untouched", src_q[0].size(), 2);
    check("t6_q2_untouched", src_q[2].size(), 2);
    check("t6_idle", busy, 0);
    chan_mask = 4'b0000;
    drain("t6");
`endif

    // Test 7: random packets with random downstream backpressure
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        int ch;
        ch = $urandom_range(0, NUM_IN - 1);
        if (src_q[ch].size() < 8)
          add_pkt(ch, $urandom_range(1, 4), 8'($urandom_range(0, 255)));
      end
      or_next = ($urandom_range(0, 3) != 0);
      step();
    end
    or_next = 1'b1;
    drain("t7");
    check("t7_exp_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
